imem_line_responder: RTL and testbench

IMEM_LINE_RESPONDER -- requirements
Module: imem_line_responder

---
 rtl/imem_line_responder_pkg.sv | 24 ++
 rtl/imem_line_assembler.sv | 51 +++++
 rtl/imem_line_responder.sv | 116 +++++++++++
 tb/tb_imem_line_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_line_responder_pkg.sv
// Shared icache definitions: responder state encoding and line geometry helpers.
package imem_line_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_RESP    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    function automatic int line_bits(input int block_size, input int num_blocks);
        return 8 * block_size * num_blocks;
    endfunction

    // Number of 32-bit backing-store words that make up one cache line.
    function automatic int line_words(input int block_size, input int num_blocks);
        return line_bits(block_size, num_blocks) / 32;
    endfunction

    function automatic int beat_bits(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/imem_line_assembler.sv
// Beat counter plus word-insert line register; each read word lands one cycle after its strobe.
module imem_line_assembler
    import imem_line_responder_pkg::*;
#(
    parameter int W      = 2,
    parameter int BEAT_W = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear_i,
    input  logic              strobe_i,
    input  logic [31:0]       rd_data_i,
    output logic [BEAT_W-1:0] beat_o,
    output logic              final_o,
    output logic [32*W-1:0]   line_o
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(W - 1);

    logic [BEAT_W-1:0] beat_q;
    logic [BEAT_W-1:0] cap_idx_q;
    logic              cap_vld_q;
    logic [32*W-1:0]   line_q;

    // clear_i drops any capture still in flight, so an aborted word never lands.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beat_q    <= '0;
            cap_idx_q <= '0;
            cap_vld_q <= 1'b0;
            line_q    <= '0;
        end else if (clear_i) begin
            beat_q    <= '0;
            cap_vld_q <= 1'b0;
        end else begin
            cap_vld_q <= strobe_i;
            cap_idx_q <= beat_q;
            if (strobe_i && (beat_q != LAST_BEAT)) begin
                beat_q <= beat_q + BEAT_W'(1);
            end
            if (cap_vld_q) begin
                line_q[32*cap_idx_q +: 32] <= rd_data_i;
            end
        end
    end

    assign beat_o  = beat_q;
    assign final_o = cap_vld_q && (cap_idx_q == LAST_BEAT) && !clear_i;
    assign line_o  = line_q;

endmodule

// File: rtl/imem_line_responder.sv
// Instruction-memory line responder: fetches one cache line as W ROM words and answers with a one-cycle ready.
module imem_line_responder
    import imem_line_responder_pkg::*;
#(
    parameter int BLOCK_SIZE = 2,
    parameter int NUM_BLOCKS = 4,
    parameter int MEM_AW     = 16
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                mem_req_valid,
    output logic                                mem_req_ready,
    input  logic [31:0]                         mem_req_addr,
    output logic [8*BLOCK_SIZE*NUM_BLOCKS-1:0]  mem_req_rdata,
    output logic                                rom_rd_en,
    output logic [MEM_AW-1:0]                   rom_rd_addr,
    input  logic [31:0]                         rom_rd_data
);

    localparam int              LINE_W    = line_bits(BLOCK_SIZE, NUM_BLOCKS);
    localparam int              W         = line_words(BLOCK_SIZE, NUM_BLOCKS);
    localparam int              BEAT_W    = beat_bits(W);
    localparam int              IDX_SHIFT = $clog2(NUM_BLOCKS) + 2;
    localparam logic [31:0]     W_WORD    = 32'(W);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(W - 1);

    generate
        if (((LINE_W % 32) != 0) || (W < 1)) begin : g_line_w_check
            $error("imem_line_responder: line width must be a non-zero multiple of 32 bits");
        end
    endgenerate

    state_e              state_q;
    logic                ready_q;
    logic                rd_en_q;
    logic [MEM_AW-1:0]   rd_addr_q;

    logic                accept;
    logic                abort;
    logic                strobe;
    logic                final_cap;
    logic [BEAT_W-1:0]   beat;

    assign accept = (state_q == ST_IDLE) && mem_req_valid;
    assign abort  = (state_q == ST_FETCH) && !mem_req_valid;
    assign strobe = rd_en_q && mem_req_valid;

    imem_line_assembler #(
        .W      (W),
        .BEAT_W (BEAT_W)
    ) u_asm (
        .clk       (clk),
        .resetn    (resetn),
        .clear_i   (accept || abort),
        .strobe_i  (strobe),
        .rd_data_i (rom_rd_data),
        .beat_o    (beat),
        .final_o   (final_cap),
        .line_o    (mem_req_rdata)
    );

    // The start address is computed once at acceptance, so later address changes cannot disturb the fetch.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mem_req_valid) begin
                        state_q   <= ST_FETCH;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= MEM_AW'((mem_req_addr >> IDX_SHIFT) * W_WORD);
                    end
                end
                ST_FETCH: begin
                    if (!mem_req_valid) begin
                        state_q <= ST_IDLE;
                        rd_en_q <= 1'b0;
                    end else begin
                        if (rd_en_q) begin
                            if (beat == LAST_BEAT) begin
                                rd_en_q <= 1'b0;
                            end else begin
                                rd_addr_q <= rd_addr_q + MEM_AW'(1);
                            end
                        end
                        if (final_cap) begin
                            state_q <= ST_RESP;
                            ready_q <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    state_q <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!mem_req_valid) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req_ready = ready_q;
    assign rom_rd_en     = rd_en_q;
    assign rom_rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_imem_line_responder.sv
// Directed bench for imem_line_responder at default geometry (two ROM words per line).
module tb_imem_line_responder;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic [63:0] mem_req_rdata;
    logic        rom_rd_en;
    logic [15:0] rom_rd_addr;
    logic [31:0] rom_rd_data;

    logic [31:0] rom [0:65535];

    int vec_n = 0;
    int err_n = 0;

    imem_line_responder dut (
        .clk           (clk),
        .resetn        (resetn),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_rdata (mem_req_rdata),
        .rom_rd_en     (rom_rd_en),
        .rom_rd_addr   (rom_rd_addr),
        .rom_rd_data   (rom_rd_data)
    );

    always #5 clk = ~clk;

    // Backing store: registered read, garbage whenever no strobe was issued.
    always @(posedge clk) begin
        rom_rd_data <= rom_rd_en ? rom[rom_rd_addr] : 32'hDEAD_BEEF;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Line = words index*W .. index*W+W-1, index = addr/16, wrapping in a 64K-word store.
    function automatic logic [15:0] first_word(input logic [31:0] a);
        logic [31:0] idx;
        idx = a / 32'd16;
        return 16'((idx * 32'd2) % 32'd65536);
    endfunction

    function automatic logic [63:0] line_of(input logic [31:0] a);
        logic [15:0] w0;
        logic [15:0] w1;
        w0 = first_word(a);
        w1 = w0 + 16'd1;
        return {rom[w1], rom[w0]};
    endfunction

    // Reference model: tracks each request by its acceptance edge and predicts outputs by offset.
    int          n = 0;
    int          acc_t = 0;
    int          rel_t = 0;
    bit          busy = 0;
    bit          fetching = 0;
    bit          hold_chk = 0;
    logic [15:0] base = '0;
    logic [63:0] cur_line = '0;
    logic [63:0] exp_line = '0;
    bit          e_en = 0;
    bit          e_rdy = 0;
    logic [15:0] e_addr = '0;

    always @(posedge clk) begin
        if (!resetn) begin
            busy     = 0;
            fetching = 0;
            e_en     = 0;
            e_rdy    = 0;
            hold_chk = 1;
            exp_line = '0;
        end else begin
            e_en  = 0;
            e_rdy = 0;
            if (!busy) begin
                if (mem_req_valid) begin
                    busy     = 1;
                    fetching = 1;
                    acc_t    = n;
                    base     = first_word(mem_req_addr);
                    cur_line = line_of(mem_req_addr);
                    hold_chk = 0;
                end
            end else if (fetching) begin
                if (!mem_req_valid) begin
                    busy     = 0;
                    fetching = 0;
                end else if (n - acc_t == W + 1) begin
                    fetching = 0;
                    e_rdy    = 1;
                    exp_line = cur_line;
                    hold_chk = 1;
                    rel_t    = n + 2;
                end
            end else begin
                if (n >= rel_t && !mem_req_valid) busy = 0;
            end
            if (fetching && (n - acc_t) < W) begin
                e_en   = 1;
                e_addr = base + 16'(n - acc_t);
            end
        end
        n++;
    end

    logic [15:0] strobes[$];
    int          ready_cnt = 0;

    always @(negedge clk) begin
        if (!resetn) begin
            check("rst_rd_en", rom_rd_en, 0);
            check("rst_ready", mem_req_ready, 0);
            check("rst_rd_addr", rom_rd_addr, 0);
            check("rst_rdata", mem_req_rdata, 0);
        end else begin
            check("rd_en", rom_rd_en, e_en);
            check("ready", mem_req_ready, e_rdy);
            if (e_en) check("rd_addr", rom_rd_addr, e_addr);
            if (hold_chk) check("rdata", mem_req_rdata, exp_line);
            if (rom_rd_en) strobes.push_back(rom_rd_addr);
            if (mem_req_ready) ready_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        strobes.delete();
        ready_cnt = 0;
    endtask

    task automatic wait_ready();
        bit got;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req_ready) begin
                got = 1;
                break;
            end
        end
        check("ready_seen", got, 1);
    endtask

    initial begin
        resetn        = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        for (int i = 0; i < 65536; i++) rom[i] = (i * 32'h9E37_79B9) ^ 32'h1234_5678;
        rom[4] = 32'hAAAA_0001;
        rom[5] = 32'hBBBB_0002;

        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_en", rom_rd_en, 0);
        check("reset_ready", mem_req_ready, 0);
        check("reset_rdata", mem_req_rdata, 0);
        check("reset_rd_addr", rom_rd_addr, 0);
        #1;
        resetn = 1'b1;

        // Basic line at 0x20, valid held three cycles past the ready pulse.
        clear_mon();
        mem_req_valid = 1'b1;
        mem_req_addr  = 32'h20;
        wait_ready();
        check("line20_rdata", mem_req_rdata, 64'hBBBB0002_AAAA0001);
        repeat (3) step();
        mem_req_valid = 1'b0;
        repeat (4) step();
        check("line20_nstrobe", strobes.size(), 2);
        if (strobes.size() == 2) begin
            check("line20_addr0", strobes[0], 16'h0004);
            check("line20_addr1", strobes[1], 16'h0005);
        end
        check("line20_nready", ready_cnt, 1);

        // Abort after the first fetch cycle, then re-request immediately.
        clear_mon();
        mem_req_valid = 1'b1;
        mem_req_addr  = 32'h40;
        step();
        step();
        mem_req_valid = 1'b0;
        step();
        check("abort_nready", ready_cnt, 0);
        check("abort_nstrobe", strobes.size(), 2);
        if (strobes.size() == 2) begin
            check("abort_addr0", strobes[0], 16'h0008);
            check("abort_addr1", strobes[1], 16'h0009);
        end
        clear_mon();
        mem_req_valid = 1'b1;
        mem_req_addr  = 32'h00;
        wait_ready();
        check("line00_rdata", mem_req_rdata, {rom[1], rom[0]});
        step();
        mem_req_valid = 1'b0;
        repeat (3) step();

        // Index wraps in the 16-bit word address.
        clear_mon();
        mem_req_valid = 1'b1;
        mem_req_addr  = 32'hFFFF_FFF0;
        wait_ready();
        check("wrap_nstrobe", strobes.size(), 2);
        if (strobes.size() == 2) begin
            check("wrap_addr0", strobes[0], 16'hFFFE);
            check("wrap_addr1", strobes[1], 16'hFFFF);
        end
        check("wrap_rdata", mem_req_rdata, {rom[16'hFFFF], rom[16'hFFFE]});
        step();
        mem_req_valid = 1'b0;
        repeat (3) step();

        // Reset pulsed mid-fetch; outputs must clear before any clock edge.
        mem_req_valid = 1'b1;
        mem_req_addr  = 32'h20;
        step();
        step();
        check("prerst_rd_en", rom_rd_en, 1);
        resetn        = 1'b0;
        mem_req_valid = 1'b0;
        #1;
        check("async_rd_en", rom_rd_en, 0);
        check("async_ready", mem_req_ready, 0);
        check("async_rd_addr", rom_rd_addr, 0);
        check("async_rdata", mem_req_rdata, 0);
        step();
        resetn        = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_addr  = 32'h08;
        wait_ready();
        step();
        mem_req_valid = 1'b0;
        repeat (3) step();

        // Back-to-back icache-style requests.
        clear_mon();
        for (int i = 0; i < 8; i++) begin
            mem_req_valid = 1'b1;
            mem_req_addr  = $urandom();
            wait_ready();
            step();
            mem_req_valid = 1'b0;
            step();
        end
        repeat (3) step();
        check("b2b_nready", ready_cnt, 8);
        check("b2b_nstrobe", strobes.size(), 16);

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end

endmodule
